// File: rtl/sensor_i2c_frame_seq.sv
// sensor_i2c_frame_seq: frame-synchronised I2C command sequencer for one sensor channel.
// Latency: a write to the current slot with run=1 and the reader idle raises i2c_cmd_valid
//          three cycles after the write strobe; peak rate is one command per three cycles.
// Backpressure: i2c_cmd_valid/i2c_cmd_data are held until i2c_cmd_ready is sampled high;
//          writes to a full slot are dropped and flagged through the sticky overflow bit.
//
// Ports:
//   mclk, rst            clock and synchronous active-high reset
//   cmd_abs / cmd_rel    queue cmd_data into slot cmd_slot / (frame_num + cmd_slot)
//   cmd_ctrl             control write: cmd_data[0] flush, [1] run, [2] clear sticky, [3] frame_num := 0
//   frame_sync           frame start pulse, releases the next slot
//   i2c_cmd_*            valid/ready command stream to the I2C byte engine
//   frame_num            current frame slot
//   busy                 commands pending, slots not yet retired, or a command in flight
//   overflow, late       sticky status flags
module sensor_i2c_frame_seq #(
  parameter int FRAME_SLOT_BITS = 4,
  parameter int SLOT_DEPTH_BITS = 4,
  parameter int DATA_WIDTH      = 32
) (
  input  logic                       mclk,
  input  logic                       rst,
  input  logic                       cmd_abs,
  input  logic                       cmd_rel,
  input  logic                       cmd_ctrl,
  input  logic [FRAME_SLOT_BITS-1:0] cmd_slot,
  input  logic [DATA_WIDTH-1:0]      cmd_data,
  input  logic                       frame_sync,
  output logic                       i2c_cmd_valid,
  output logic [DATA_WIDTH-1:0]      i2c_cmd_data,
  input  logic                       i2c_cmd_ready,
  output logic [FRAME_SLOT_BITS-1:0] frame_num,
  output logic                       busy,
  output logic                       overflow,
  output logic                       late
);

  localparam int NSLOT = 1 << FRAME_SLOT_BITS;
  localparam int DEPTH = 1 << SLOT_DEPTH_BITS;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_FETCH   = 2'd1;
  localparam logic [1:0] ST_PRESENT = 2'd2;

  localparam logic [FRAME_SLOT_BITS-1:0] SLOT_ONE = {{(FRAME_SLOT_BITS-1){1'b0}}, 1'b1};
  localparam logic [FRAME_SLOT_BITS-1:0] LAG_MAX  = '1;
  localparam logic [SLOT_DEPTH_BITS:0]   CNT_ONE  = {{SLOT_DEPTH_BITS{1'b0}}, 1'b1};
  localparam logic [SLOT_DEPTH_BITS:0]   CNT_FULL = {1'b1, {SLOT_DEPTH_BITS{1'b0}}};

  // Reader and control state
  logic [1:0]                 state;
  logic                       run;
  logic [FRAME_SLOT_BITS-1:0] rd_slot;
  logic [FRAME_SLOT_BITS-1:0] lag;
  logic [SLOT_DEPTH_BITS:0]   rd_ptr;
  logic [SLOT_DEPTH_BITS:0]   wr_cnt [NSLOT];

  // Command storage, addressed {slot, index}
  logic [DATA_WIDTH-1:0]      mem [NSLOT*DEPTH];
  logic [DATA_WIDTH-1:0]      ram_q;

  // Decoded strobes and next-state helpers
  logic                       ctrl_flush;
  logic                       ctrl_clr;
  logic                       ctrl_zero;
  logic                       wr_en;
  logic [FRAME_SLOT_BITS-1:0] wr_slot;
  logic [SLOT_DEPTH_BITS-1:0] wr_idx;
  logic                       wr_full;
  logic                       wr_ok;
  logic                       clr_hit;
  logic [SLOT_DEPTH_BITS:0]   cur_cnt;
  logic                       pending;
  logic                       adv;
  logic                       start_fetch;
  logic                       sync_late;
  logic                       lag_inc;
  logic [FRAME_SLOT_BITS-1:0] fn_next;

  always_comb begin
    ctrl_flush  = cmd_ctrl & cmd_data[0];
    ctrl_clr    = cmd_ctrl & cmd_data[2];
    ctrl_zero   = cmd_ctrl & cmd_data[3];
    // Control takes precedence over data writes; abs over rel.
    wr_en       = ~cmd_ctrl & (cmd_abs | cmd_rel);
    wr_slot     = cmd_abs ? cmd_slot : (frame_num + cmd_slot);

    cur_cnt     = wr_cnt[rd_slot];
    pending     = (rd_ptr < cur_cnt);
    // Retire a fully drained slot that is behind the current frame.
    adv         = (state == ST_IDLE) && (rd_ptr == cur_cnt) && (lag != '0);
    start_fetch = (state == ST_IDLE) && run && pending && !ctrl_flush;

    // A write into the slot being retired this cycle starts that slot afresh.
    clr_hit     = adv && (wr_slot == rd_slot);
    wr_full     = (wr_cnt[wr_slot] == CNT_FULL) && !clr_hit;
    wr_ok       = wr_en && !wr_full;
    wr_idx      = clr_hit ? '0 : wr_cnt[wr_slot][SLOT_DEPTH_BITS-1:0];

    sync_late   = frame_sync && ((lag != '0) || pending);
    lag_inc     = frame_sync && (lag != LAG_MAX);

    if (ctrl_zero) begin
      fn_next = '0;
    end else if (frame_sync) begin
      fn_next = frame_num + SLOT_ONE;
    end else begin
      fn_next = frame_num;
    end
  end

  assign busy = (state != ST_IDLE) || (lag != '0) || pending;

  // Synchronous-read RAM. The read address follows the reader every cycle, so the
  // word addressed in IDLE is available in ram_q during FETCH.
  always_ff @(posedge mclk) begin
    if (wr_ok) begin
      mem[{wr_slot, wr_idx}] <= cmd_data;
    end
    ram_q <= mem[{rd_slot, rd_ptr[SLOT_DEPTH_BITS-1:0]}];
  end

  // Per-slot write counts
  always_ff @(posedge mclk) begin
    if (rst) begin
      for (int s = 0; s < NSLOT; s++) begin
        wr_cnt[s] <= '0;
      end
    end else begin
      for (int s = 0; s < NSLOT; s++) begin
        if (ctrl_flush) begin
          wr_cnt[s] <= '0;
        end else if (wr_ok && (wr_slot == FRAME_SLOT_BITS'(s))) begin
          wr_cnt[s] <= clr_hit ? CNT_ONE : (wr_cnt[s] + CNT_ONE);
        end else if (adv && (rd_slot == FRAME_SLOT_BITS'(s))) begin
          wr_cnt[s] <= '0;
        end
      end
    end
  end

  // Frame tracking, reader pointers, status flags and the output FSM
  always_ff @(posedge mclk) begin
    if (rst) begin
      state         <= ST_IDLE;
      run           <= 1'b0;
      rd_slot       <= '0;
      rd_ptr        <= '0;
      lag           <= '0;
      frame_num     <= '0;
      overflow      <= 1'b0;
      late          <= 1'b0;
      i2c_cmd_valid <= 1'b0;
      i2c_cmd_data  <= '0;
    end else begin
      frame_num <= fn_next;

      if (cmd_ctrl) begin
        run <= cmd_data[1];
      end

      // Set events win over a clear in the same cycle.
      if (wr_en && wr_full) begin
        overflow <= 1'b1;
      end else if (ctrl_clr) begin
        overflow <= 1'b0;
      end

      if (sync_late) begin
        late <= 1'b1;
      end else if (ctrl_clr) begin
        late <= 1'b0;
      end

      // A flush realigns the reader with the frame being entered; a command already
      // in FETCH/PRESENT still completes because the FSM below ignores the flush.
      if (ctrl_flush) begin
        lag     <= '0;
        rd_ptr  <= '0;
        rd_slot <= fn_next;
      end else begin
        if (adv) begin
          rd_slot <= rd_slot + SLOT_ONE;
          rd_ptr  <= '0;
        end else if (state == ST_FETCH) begin
          rd_ptr <= rd_ptr + CNT_ONE;
        end
        lag <= lag + FRAME_SLOT_BITS'(lag_inc) - FRAME_SLOT_BITS'(adv);
      end

      case (state)
        ST_IDLE: begin
          if (start_fetch) begin
            state <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          i2c_cmd_data  <= ram_q;
          i2c_cmd_valid <= 1'b1;
          state         <= ST_PRESENT;
        end
        ST_PRESENT: begin
          if (i2c_cmd_ready) begin
            i2c_cmd_valid <= 1'b0;
            state         <= ST_IDLE;
          end
        end
        default: begin
          i2c_cmd_valid <= 1'b0;
          state         <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sensor_i2c_frame_seq.sv
// Testbench for sensor_i2c_frame_seq: cycle table, directed multi-cycle sequences,
// and a randomized run against a slot-queue reference model.
module tb_sensor_i2c_frame_seq;

  logic        mclk = 1'b0;
  logic        rst;
  logic        cmd_abs, cmd_rel, cmd_ctrl, frame_sync, i2c_cmd_ready;
  logic [3:0]  cmd_slot;
  logic [31:0] cmd_data;
  logic        i2c_cmd_valid;
  logic [31:0] i2c_cmd_data;
  logic [3:0]  frame_num;
  logic        busy, overflow, late;

  sensor_i2c_frame_seq #(.FRAME_SLOT_BITS(4), .SLOT_DEPTH_BITS(4), .DATA_WIDTH(32)) dut (
    .mclk(mclk), .rst(rst), .cmd_abs(cmd_abs), .cmd_rel(cmd_rel), .cmd_ctrl(cmd_ctrl),
    .cmd_slot(cmd_slot), .cmd_data(cmd_data), .frame_sync(frame_sync),
    .i2c_cmd_valid(i2c_cmd_valid), .i2c_cmd_data(i2c_cmd_data), .i2c_cmd_ready(i2c_cmd_ready),
    .frame_num(frame_num), .busy(busy), .overflow(overflow), .late(late)
  );

  always #5 mclk = ~mclk;

  int n_cmp = 0;
  int n_fail = 0;
  int n_issued = 0;
  bit mon_en = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // ---------------- reference model: one FIFO per frame slot ----------------
  logic [31:0] mdat [16][16];
  int          mhead [16];
  int          mtail [16];
  int          mfn, mrs;
  bit          carry_v;
  logic [31:0] carry_d;

  task automatic m_reset();
    for (int s = 0; s < 16; s++) begin mhead[s] = 0; mtail[s] = 0; end
    mfn = 0; mrs = 0; carry_v = 0;
  endtask

  task automatic m_push(input int slot, input logic [31:0] d);
    int s = slot % 16;
    if (mtail[s] < 16) begin mdat[s][mtail[s]] = d; mtail[s]++; end
  endtask

  // Move to the oldest released slot holding data; slots beyond the frame stay locked.
  task automatic m_seek(output bit ok);
    while (mhead[mrs] == mtail[mrs] && mrs != mfn) begin
      mhead[mrs] = 0; mtail[mrs] = 0; mrs = (mrs + 1) % 16;
    end
    ok = (mhead[mrs] != mtail[mrs]);
  endtask

  task automatic m_pop(input logic [31:0] got);
    bit ok;
    if (carry_v) begin
      chk("issue_inflight", got, carry_d);
      carry_v = 0;
    end else begin
      m_seek(ok);
      if (!ok) begin
        n_cmp++; n_fail++;
        $display("FAIL unexpected_issue: got %0h expected no command", got);
      end else begin
        chk("issue_order", got, mdat[mrs][mhead[mrs]]);
        mhead[mrs]++;
      end
    end
  endtask

  task automatic m_flush(input int fnn);
    bit ok;
    if (i2c_cmd_valid && !carry_v) begin
      m_seek(ok);
      if (ok) begin carry_v = 1; carry_d = mdat[mrs][mhead[mrs]]; end
    end
    for (int s = 0; s < 16; s++) begin mhead[s] = 0; mtail[s] = 0; end
    mrs = fnn;
  endtask

  // ---------------- monitor ----------------
  bit          pv = 0, phs = 0, prst = 0;
  logic [31:0] pd = '0;
  always @(negedge mclk) begin
    if (mon_en) begin
      if (pv && !phs && !prst) begin
        chk("hold_valid", i2c_cmd_valid, 1'b1);
        chk("hold_data", i2c_cmd_data, pd);
      end
      if (i2c_cmd_valid && i2c_cmd_ready) begin
        n_issued++;
        m_pop(i2c_cmd_data);
      end
      pv = i2c_cmd_valid; phs = i2c_cmd_valid && i2c_cmd_ready; pd = i2c_cmd_data; prst = rst;
    end else begin
      pv = 0; phs = 0; prst = 0;
    end
  end

  // ---------------- drivers ----------------
  task automatic tick(); @(posedge mclk); #1; endtask

  task automatic drv_rel(input logic [3:0] off, input logic [31:0] d);
    cmd_rel = 1; cmd_slot = off; cmd_data = d; m_push(mfn + off, d);
    tick(); cmd_rel = 0;
  endtask

  task automatic drv_abs(input logic [3:0] slot, input logic [31:0] d);
    cmd_abs = 1; cmd_slot = slot; cmd_data = d; m_push(slot, d);
    tick(); cmd_abs = 0;
  endtask

  task automatic drv_sync();
    frame_sync = 1; mfn = (mfn + 1) % 16;
    tick(); frame_sync = 0;
  endtask

  task automatic drv_ctrl(input logic [3:0] c);
    int fnn = c[3] ? 0 : mfn;
    cmd_ctrl = 1; cmd_data = {28'd0, c};
    if (c[0]) m_flush(fnn);
    mfn = fnn;
    tick(); cmd_ctrl = 0;
  endtask

  task automatic drv_rst();
    rst = 1; m_reset();
    tick(); rst = 0;
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int k = 0;
    while (busy === 1'b1 && k < budget) begin tick(); k++; end
    chk(nm, (k < budget), 1'b1);
  endtask

  task automatic wait_valid(input int budget, input string nm);
    int k = 0;
    while (i2c_cmd_valid !== 1'b1 && k < budget) begin tick(); k++; end
    chk(nm, (k < budget), 1'b1);
  endtask

  // ---------------- cycle table ----------------
  typedef struct {
    logic ctrl, rel, sync, ready;
    logic [31:0] din;
    logic ev; logic [31:0] ed; logic eb; logic [3:0] efn; logic el;
  } vec_t;

  function automatic vec_t mk(input logic ctrl, rel, sync, ready, input logic [31:0] din,
                              input logic ev, input logic [31:0] ed, input logic eb,
                              input logic [3:0] efn, input logic el);
    vec_t v;
    v.ctrl = ctrl; v.rel = rel; v.sync = sync; v.ready = ready; v.din = din;
    v.ev = ev; v.ed = ed; v.eb = eb; v.efn = efn; v.el = el;
    return v;
  endfunction

  localparam logic [31:0] WA = 32'hA5A5_0001;
  localparam logic [31:0] WB = 32'h0000_0011;

  initial begin
    vec_t tbl [28];
    int base, tot_w, remain, nw;
    logic [3:0] off;

    //            ctrl rel sync rdy din     v  data eb fn el
    tbl[0]  = mk(1, 0, 0, 0, 32'd2, 0, 0,  0, 0, 0);
    tbl[1]  = mk(0, 1, 0, 0, WA,    0, 0,  0, 0, 0);
    tbl[2]  = mk(0, 0, 0, 0, 0,     0, 0,  1, 0, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0,     0, 0,  1, 0, 0);
    tbl[4]  = mk(0, 0, 0, 0, 0,     1, WA, 1, 0, 0);
    tbl[5]  = mk(0, 0, 0, 0, 0,     1, WA, 1, 0, 0);
    tbl[6]  = mk(0, 0, 0, 0, 0,     1, WA, 1, 0, 0);
    tbl[7]  = mk(0, 0, 0, 0, 0,     1, WA, 1, 0, 0);
    tbl[8]  = mk(0, 0, 0, 0, 0,     1, WA, 1, 0, 0);
    tbl[9]  = mk(0, 0, 0, 1, 0,     1, WA, 1, 0, 0);
    tbl[10] = mk(0, 0, 0, 0, 0,     0, WA, 0, 0, 0);
    tbl[11] = mk(0, 0, 1, 0, 0,     0, WA, 0, 0, 0);
    tbl[12] = mk(0, 0, 0, 0, 0,     0, WA, 1, 1, 0);
    tbl[13] = mk(1, 0, 0, 0, 32'd0, 0, WA, 0, 1, 0);
    tbl[14] = mk(0, 1, 0, 0, WB,    0, WA, 0, 1, 0);
    tbl[15] = mk(0, 0, 1, 0, 0,     0, WA, 1, 1, 0);
    tbl[16] = mk(0, 0, 0, 0, 0,     0, WA, 1, 2, 1);
    tbl[17] = mk(1, 0, 1, 0, 32'd6, 0, WA, 1, 2, 1);
    tbl[18] = mk(0, 0, 0, 0, 0,     0, WA, 1, 3, 1);
    tbl[19] = mk(0, 0, 0, 0, 0,     0, WA, 1, 3, 1);
    tbl[20] = mk(0, 0, 0, 1, 0,     1, WB, 1, 3, 1);
    tbl[21] = mk(0, 0, 0, 0, 0,     0, WB, 1, 3, 1);
    tbl[22] = mk(0, 0, 0, 0, 0,     0, WB, 1, 3, 1);
    tbl[23] = mk(0, 0, 0, 0, 0,     0, WB, 0, 3, 1);
    tbl[24] = mk(1, 0, 0, 0, 32'd4, 0, WB, 0, 3, 1);
    tbl[25] = mk(0, 0, 0, 0, 0,     0, WB, 0, 3, 0);
    tbl[26] = mk(1, 0, 0, 0, 32'd8, 0, WB, 0, 3, 0);
    tbl[27] = mk(0, 0, 0, 0, 0,     0, WB, 0, 0, 0);

    rst = 1; cmd_abs = 0; cmd_rel = 0; cmd_ctrl = 0; frame_sync = 0;
    i2c_cmd_ready = 0; cmd_slot = 0; cmd_data = 0;
    m_reset();
    tick(); tick();
    rst = 0;

    for (int i = 0; i < 28; i++) begin
      cmd_ctrl = tbl[i].ctrl; cmd_rel = tbl[i].rel; cmd_slot = 4'd0;
      cmd_data = tbl[i].din; frame_sync = tbl[i].sync; i2c_cmd_ready = tbl[i].ready;
      @(negedge mclk);
      chk($sformatf("vec%0d", i),
          {i2c_cmd_valid, i2c_cmd_data, busy, frame_num, overflow, late},
          {tbl[i].ev, tbl[i].ed, tbl[i].eb, tbl[i].efn, 1'b0, tbl[i].el});
      tick();
    end
    cmd_ctrl = 0; cmd_rel = 0; frame_sync = 0; cmd_data = 0;

    // Words queued two frames ahead are released only by the second sync.
    drv_rst(); i2c_cmd_ready = 1; mon_en = 1;
    drv_ctrl(4'b0010);
    base = n_issued;
    drv_abs(4'd2, 32'hB000_0001); drv_abs(4'd2, 32'hB000_0002); drv_abs(4'd2, 32'hB000_0003);
    repeat (3) tick();
    drv_sync();
    repeat (20) tick();
    chk("s2_none_early", n_issued - base, 0);
    drv_sync();
    wait_idle(100, "s2_idle_timeout");
    chk("s2_count", n_issued - base, 3);
    chk("s2_late", late, 1'b0);

    // Slot capacity: the 17th write is dropped and flagged.
    drv_rst();
    base = n_issued;
    for (int i = 0; i < 17; i++) begin
      drv_abs(4'd5, 32'hC000_0000 + i);
      if (i == 15) chk("s3_ovf_at_16", overflow, 1'b0);
    end
    chk("s3_ovf_set", overflow, 1'b1);
    drv_ctrl(4'b0110);
    chk("s3_ovf_clr", overflow, 1'b0);
    repeat (5) begin drv_sync(); tick(); end
    wait_idle(300, "s3_idle_timeout");
    chk("s3_count", n_issued - base, 16);

    // Stopped reader falls behind, then catches up slot by slot.
    drv_rst();
    drv_abs(4'd1, 32'h0000_0100); drv_abs(4'd1, 32'h0000_0101); drv_abs(4'd2, 32'h0000_0200);
    base = n_issued;
    repeat (3) begin drv_sync(); tick(); tick(); end
    chk("s4_late", late, 1'b1);
    chk("s4_busy", busy, 1'b1);
    chk("s4_none_stopped", n_issued - base, 0);
    drv_ctrl(4'b0010);
    wait_idle(100, "s4_idle_timeout");
    chk("s4_count", n_issued - base, 3);

    // Flush while presenting: only the presented word completes.
    drv_rst(); i2c_cmd_ready = 0;
    drv_ctrl(4'b0010);
    base = n_issued;
    for (int i = 0; i < 5; i++) drv_rel(4'd0, 32'hD000_0000 + i);
    wait_valid(20, "s5_valid_timeout");
    drv_ctrl(4'b0011);
    chk("s5_valid_kept", i2c_cmd_valid, 1'b1);
    chk("s5_data_kept", i2c_cmd_data, 32'hD000_0000);
    i2c_cmd_ready = 1;
    repeat (30) tick();
    chk("s5_count", n_issued - base, 1);
    chk("s5_busy", busy, 1'b0);

    // Reset while presenting drops valid with no handshake.
    drv_rst(); i2c_cmd_ready = 0;
    drv_ctrl(4'b0010);
    drv_sync();
    drv_rel(4'd0, 32'hE000_0001);
    wait_valid(20, "s6_valid_timeout");
    chk("s6_fn_before", frame_num, 4'd1);
    drv_rst();
    chk("s6_valid_rst", i2c_cmd_valid, 1'b0);
    chk("s6_fn_rst", frame_num, 4'd0);
    chk("s6_busy_rst", busy, 1'b0);
    base = n_issued;
    drv_ctrl(4'b0010);
    i2c_cmd_ready = 1;
    repeat (20) tick();
    chk("s6_no_issue", n_issued - base, 0);

    // Randomized traffic against the slot model.
    drv_rst();
    drv_ctrl(4'b0010);
    base = n_issued; tot_w = 0;
    for (int f = 0; f < 27; f++) begin
      nw = 0;
      for (int c = 0; c < 60; c++) begin
        i2c_cmd_ready = ($urandom_range(0, 3) != 0);
        if (f < 25 && c < 20 && nw < 4 && $urandom_range(0, 3) == 0) begin
          off = 4'($urandom_range(0, 2));
          if ($urandom_range(0, 1) == 1) drv_rel(off, $urandom);
          else drv_abs(4'((mfn + off) % 16), $urandom);
          nw++; tot_w++;
        end else if (c == 59) begin
          drv_sync();
        end else begin
          tick();
        end
      end
    end
    i2c_cmd_ready = 1;
    wait_idle(500, "rnd_idle_timeout");
    remain = carry_v ? 1 : 0;
    for (int s = 0; s < 16; s++) remain += mtail[s] - mhead[s];
    chk("rnd_remaining", remain, 0);
    chk("rnd_count", n_issued - base, tot_w);
    chk("rnd_ovf", overflow, 1'b0);

    mon_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
